// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction buffer: a circular FIFO of {pc, inst, excp, ecode}
// with flush on redirect and a NOP presented to decode whenever it is empty.
module fetch_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_excp,
  input  logic [5:0]               in_ecode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_excp,
  output logic [5:0]               out_ecode,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] NopInst = 32'h0340_0000;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  // Payload storage carries no reset; only the pointers and count qualify it.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] inst_mem  [DEPTH];
  logic        excp_mem  [DEPTH];
  logic [5:0]  ecode_mem [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  // Readiness ignores out_ready: a full buffer refuses even if it pops this cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && !full && !flush;
  assign pop  = !empty && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Reset does not gate the write: a stale write is harmless since count is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      inst_mem[wr_ptr_q]  <= in_inst;
      excp_mem[wr_ptr_q]  <= in_excp;
      ecode_mem[wr_ptr_q] <= in_ecode;
    end
  end

  always_comb begin
    out_pc    = '0;
    out_inst  = NopInst;
    out_excp  = 1'b0;
    out_ecode = '0;
    if (!empty) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_inst  = inst_mem[rd_ptr_q];
      out_excp  = excp_mem[rd_ptr_q];
      out_ecode = ecode_mem[rd_ptr_q];
    end
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have one parameter, listed below.
- DEPTH, 8, number of entries; power of two, at least 2.

REQ-002 The block SHALL have the following ports.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all entries (branch mispredict, exception or ertn redirect).
- in_valid  in  1  fetch stage presents an instruction.
- in_ready  out  1  buffer can accept this cycle.
- in_pc  in  32  instruction PC.
- in_inst  in  32  raw instruction word.
- in_excp  in  1  fetch-side exception attached (ADEF, TLB refill, PIF, PPI).
- in_ecode  in  6  exception code, meaningful only when in_excp=1.
- out_valid  out  1  head entry is available to decode.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction word, fed directly to the decoder inst input.
- out_excp  out  1  head exception flag.
- out_ecode  out  6  head exception code.
- count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-003 Storage SHALL be a circular FIFO of DEPTH entries of {pc, inst, excp, ecode}, with a read pointer, a write pointer (each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0) and an occupancy counter.
REQ-004 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready; a push into a full buffer is refused even when a pop happens in the same cycle.
REQ-005 A push SHALL occur when in_valid && in_ready && !flush: the entry is written at the write pointer, which then advances.
REQ-006 A pop SHALL occur when out_valid && out_ready && !flush: the read pointer advances.
REQ-007 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push and pop or on neither.
REQ-008 out_valid SHALL equal (count != 0); out_pc, out_inst, out_excp and out_ecode SHALL be a combinational read of the entry at the read pointer.
REQ-009 When the buffer is empty, the outputs SHALL be forced to out_pc=0, out_inst=32'h0340_0000 (andi r0,r0,0, a NOP), out_excp=0, out_ecode=0, so that the decoder never sees stale data.
REQ-010 Latency SHALL be one cycle: an entry pushed at edge N appears with out_valid=1 after edge N; there is no same-cycle bypass from in_* to out_*.
REQ-011 Order SHALL be strictly FIFO, and no entry is dropped or duplicated across pointer wrap-around.
REQ-012 flush SHALL take priority over push and pop in the same cycle: at the next edge the read pointer, write pointer and count become 0, and the pushed instruction is discarded.
REQ-013 In the cycle flush is asserted, in_ready SHALL still follow REQ-004; the fetch stage is responsible for dropping its request.
REQ-014 An entry with in_excp=1 SHALL be stored and delivered like any other entry; its in_inst value is carried through unchanged and its excp/ecode fields pass through unmodified.
REQ-015 The per-entry payload array SHALL NOT require reset; only the pointers and count SHALL be reset.

Reset
REQ-016 When rst=1 at a clock edge, the read pointer, write pointer and count SHALL become 0.
REQ-017 Immediately after reset: out_valid=0, in_ready=1, count=0, and outputs per REQ-009.
REQ-018 rst SHALL override flush, push and pop, and mid-operation reset SHALL discard all contents.

Verification
REQ-019 Fill/drain scenario: push 8 entries with pc=0x1c000000+4i and out_ready=0 -> in_ready=0 and count=8; then out_ready=1 -> 8 pops in order, pc ascending, then out_valid=0 and out_inst=0x03400000.
REQ-020 Full with simultaneous push and pop: with count=8, assert in_valid and out_ready together -> pop only, count=7, and the pushed item is not stored.
REQ-021 Steady streaming: with in_valid=out_ready=1 for 20 cycles across wrap-around -> count stays at 1 and the output sequence equals the input sequence delayed by one cycle.
REQ-022 Flush with push: with count=5, assert flush together with in_valid -> next cycle count=0 and out_valid=0; the next push appears alone at the output.
REQ-023 Exception carry: push in_excp=1, in_ecode=6'h08 -> the entry emerges with out_excp=1 and out_ecode=6'h08, and the neighbouring entries show excp=0.
REQ-024 Reset mid-operation: with count=3, assert rst together with a push and a pop -> count=0, out_valid=0 and in_ready=1 on the next cycle.
